// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
//
// Turns raw, bouncing, asynchronous push-button levels into clean per-key
// event pulses for the three-colour light controller. Each key channel has
// a 2-FF synchroniser, a debounce filter and an IDLE/HELD/LONG_HELD state
// machine. The channels share nothing except clock and reset.
//
// Parameters
//   NUM_KEYS         number of independent key channels
//   DEBOUNCE_CYCLES  stable samples needed to accept a level change (>= 2)
//   LONG_CYCLES      hold time that qualifies a long press (> DEBOUNCE_CYCLES)
//   REPEAT_CYCLES    auto-repeat period while held past a long press
//
// Ports
//   Sys_CLK      in   1         system clock
//   Sys_RST      in   1         synchronous, active-high reset
//   Key          in   NUM_KEYS  raw key levels, asynchronous, 1 = pressed
//   Key_Stable   out  NUM_KEYS  debounced key level
//   Key_Press    out  NUM_KEYS  1-cycle pulse on debounced rising edge
//   Key_Release  out  NUM_KEYS  1-cycle pulse on debounced falling edge
//   Key_Short    out  NUM_KEYS  1-cycle pulse at release of a hold that
//                               never reached a long press
//   Key_Long     out  NUM_KEYS  1-cycle pulse when a hold reaches
//                               LONG_CYCLES (plus repeats, see below)
//
// Build option
//   KEY_REPEAT_EN  when defined, Key_Long repeats every REPEAT_CYCLES while
//                  the key stays held after the first long pulse. When not
//                  defined no repeat logic is built and Key_Long fires once
//                  per hold.
//
// Timing: a clean raw edge shows up on Key_Stable DEBOUNCE_CYCLES+2 cycles
// later; Key_Press/Key_Release/Key_Short are registered alongside Key_Stable
// so they pulse in the same cycle the new level first appears.
// ---------------------------------------------------------------------------
module key_event_decoder #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic                Sys_CLK,
    input  logic                Sys_RST,
    input  logic [NUM_KEYS-1:0] Key,
    output logic [NUM_KEYS-1:0] Key_Stable,
    output logic [NUM_KEYS-1:0] Key_Press,
    output logic [NUM_KEYS-1:0] Key_Release,
    output logic [NUM_KEYS-1:0] Key_Short,
    output logic [NUM_KEYS-1:0] Key_Long
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Hold counter is sized for the larger of the two periods so it never wraps.
    localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

`ifdef KEY_REPEAT_EN
    localparam int unsigned       REP_W    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key

        logic [1:0]        r_sync;      // [0] first stage, [1] synchronised level
        logic              r_stable;
        logic [DEB_W-1:0]  r_deb_cnt;

        logic              w_differs;
        logic              w_deb_done;
        logic              w_rise;
        logic              w_fall;

        state_t            r_state;
        state_t            w_state_nx;
        logic [HOLD_W-1:0] r_hold;
        logic [HOLD_W-1:0] w_hold_nx;

        logic              r_press;
        logic              r_release;
        logic              r_short;
        logic              r_long;
        logic              w_press_nx;
        logic              w_release_nx;
        logic              w_short_nx;
        logic              w_long_nx;

`ifdef KEY_REPEAT_EN
        logic [REP_W-1:0]  r_rep;
        logic [REP_W-1:0]  w_rep_nx;
`endif

        // Debounce decision: the accepted level flips on this edge.
        assign w_differs  = r_sync[1] ^ r_stable;
        assign w_deb_done = w_differs && (r_deb_cnt == DEB_LAST);
        assign w_rise     = w_deb_done && !r_stable;
        assign w_fall     = w_deb_done &&  r_stable;

        // Synchroniser and debounce filter.
        always_ff @(posedge Sys_CLK) begin
            if (Sys_RST) begin
                r_sync    <= 2'b00;
                r_stable  <= 1'b0;
                r_deb_cnt <= '0;
            end else begin
                r_sync <= {r_sync[0], Key[gi]};
                if (!w_differs) begin
                    r_deb_cnt <= '0;
                end else if (w_deb_done) begin
                    r_stable  <= ~r_stable;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                end
            end
        end

        // Press/hold state register and registered pulse outputs.
        always_ff @(posedge Sys_CLK) begin
            if (Sys_RST) begin
                r_state   <= ST_IDLE;
                r_hold    <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_short   <= 1'b0;
                r_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
                r_rep     <= '0;
`endif
            end else begin
                r_state   <= w_state_nx;
                r_hold    <= w_hold_nx;
                r_press   <= w_press_nx;
                r_release <= w_release_nx;
                r_short   <= w_short_nx;
                r_long    <= w_long_nx;
`ifdef KEY_REPEAT_EN
                r_rep     <= w_rep_nx;
`endif
            end
        end

        // Next state, hold counting and event generation.
        always_comb begin
            w_state_nx   = r_state;
            w_hold_nx    = r_hold;
            w_press_nx   = 1'b0;
            w_release_nx = 1'b0;
            w_short_nx   = 1'b0;
            w_long_nx    = 1'b0;
`ifdef KEY_REPEAT_EN
            w_rep_nx     = r_rep;
`endif

            case (r_state)
                ST_IDLE: begin
                    w_hold_nx = '0;
`ifdef KEY_REPEAT_EN
                    w_rep_nx  = '0;
`endif
                    if (w_rise) begin
                        w_state_nx = ST_HELD;
                        w_press_nx = 1'b1;
                    end
                end

                ST_HELD: begin
                    // A release on the same edge as the long threshold
                    // still counts as a short press.
                    if (w_fall) begin
                        w_state_nx   = ST_IDLE;
                        w_release_nx = 1'b1;
                        w_short_nx   = 1'b1;
                        w_hold_nx    = '0;
                    end else if (r_hold == LONG_LAST) begin
                        w_state_nx = ST_LONG_HELD;
                        w_long_nx  = 1'b1;
`ifdef KEY_REPEAT_EN
                        w_rep_nx   = '0;
`endif
                    end else begin
                        w_hold_nx = r_hold + HOLD_W'(1);
                    end
                end

                ST_LONG_HELD: begin
                    if (w_fall) begin
                        w_state_nx   = ST_IDLE;
                        w_release_nx = 1'b1;
                        w_hold_nx    = '0;
                    end else begin
                        if (r_hold != '1) begin
                            w_hold_nx = r_hold + HOLD_W'(1);
                        end
`ifdef KEY_REPEAT_EN
                        // Repeat pulses are spaced REPEAT_CYCLES apart,
                        // counted from the first long pulse.
                        if (r_rep == REP_LAST) begin
                            w_long_nx = 1'b1;
                            w_rep_nx  = '0;
                        end else begin
                            w_rep_nx = r_rep + REP_W'(1);
                        end
`endif
                    end
                end

                default: begin
                    w_state_nx = ST_IDLE;
                    w_hold_nx  = '0;
                end
            endcase
        end

        assign Key_Stable[gi]  = r_stable;
        assign Key_Press[gi]   = r_press;
        assign Key_Release[gi] = r_release;
        assign Key_Short[gi]   = r_short;
        assign Key_Long[gi]    = r_long;

    end : g_key

endmodule : key_event_decoder

// File: tb/tb_key_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_event_decoder
//
// Drives key_event_decoder with small timing parameters (debounce 4, long 20,
// repeat 8, 20 ns clock). Every stimulus step schedules the pulses it should
// cause into a cycle-ordered expectation queue; a monitor on the falling
// clock edge pops and compares them and demands silence on all other cycles.
// Key_Stable is tracked from the expected press/release events.
// Define KEY_REPEAT_EN for both the bench and the design to cover repeats.
// ---------------------------------------------------------------------------
module tb_key_event_decoder;

    localparam int unsigned NK   = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned REP  = 8;
    localparam int          LAT  = DEB + 2;  // raw edge to Key_Stable change

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '0;

    logic [NK-1:0] Key_Stable;
    logic [NK-1:0] Key_Press;
    logic [NK-1:0] Key_Release;
    logic [NK-1:0] Key_Short;
    logic [NK-1:0] Key_Long;

    key_event_decoder #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .Sys_CLK     (clk),
        .Sys_RST     (rst),
        .Key         (key),
        .Key_Stable  (Key_Stable),
        .Key_Press   (Key_Press),
        .Key_Release (Key_Release),
        .Key_Short   (Key_Short),
        .Key_Long    (Key_Long)
    );

    always #10 clk = ~clk;

    int   cyc   = 0;
    logic rst_q = 1'b1;   // reset value sampled at the latest rising edge
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        int            at;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] shrt;
        logic [NK-1:0] lng;
    } ev_t;

    typedef struct {
        logic [NK-1:0] key;
        int            dwell;
        logic [NK-1:0] press;   // expected LAT cycles after the drive
        logic [NK-1:0] rel;
        logic [NK-1:0] shrt;
        logic [NK-1:0] lng;     // expected LAT+LONG cycles after the drive
    } vec_t;

    ev_t           exp_q[$];
    logic [NK-1:0] exp_stable = '0;
    int            vectors    = 0;
    int            miscompares = 0;
    bit            tmo        = 1'b0;
    bit            tmo_seen   = 1'b0;

    // Insert an expected event in cycle order, merging same-cycle events.
    task automatic push_ev(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r,
                           input logic [NK-1:0] s, input logic [NK-1:0] l);
        int  idx;
        ev_t e;
        idx = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].at == at) begin
                e       = exp_q[i];
                e.press = e.press | p;
                e.rel   = e.rel | r;
                e.shrt  = e.shrt | s;
                e.lng   = e.lng | l;
                exp_q[i] = e;
                return;
            end
            if (exp_q[i].at > at) begin
                idx = i;
                break;
            end
        end
        e.at = at; e.press = p; e.rel = r; e.shrt = s; e.lng = l;
        exp_q.insert(idx, e);
    endtask

    task automatic chk(input string name, input logic [NK-1:0] got, input logic [NK-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got %b want %b", name, cyc, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare scheduled events, otherwise require quiet outputs.
    always @(negedge clk) begin
        ev_t e;
        if (tmo && !tmo_seen) begin
            tmo_seen = 1'b1;
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d events pending, want 0", exp_q.size());
        end
        if (rst_q) begin
            exp_stable = '0;
            vectors++;
            if ({Key_Stable, Key_Press, Key_Release, Key_Short, Key_Long} !== '0) begin
                miscompares++;
                $display("FAIL reset_quiet cyc %0d: got %b want 0", cyc,
                         {Key_Stable, Key_Press, Key_Release, Key_Short, Key_Long});
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_event at cyc %0d: got nothing want p%b r%b s%b l%b",
                         e.at, e.press, e.rel, e.shrt, e.lng);
            end
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                chk("press",   Key_Press,   e.press);
                chk("release", Key_Release, e.rel);
                chk("short",   Key_Short,   e.shrt);
                chk("long",    Key_Long,    e.lng);
                exp_stable = (exp_stable | e.press) & ~e.rel;
                chk("stable",  Key_Stable,  exp_stable);
            end else begin
                if ({Key_Press, Key_Release, Key_Short, Key_Long} !== '0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc %0d: got p%b r%b s%b l%b want 0",
                             cyc, Key_Press, Key_Release, Key_Short, Key_Long);
                end
                if (Key_Stable !== exp_stable) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stable_level cyc %0d: got %b want %b", cyc, Key_Stable, exp_stable);
                end
            end
        end
    end

    initial begin
        vec_t vecs[$];
        int   c;

        vecs.push_back('{2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00});  // clean short press, key 0
        vecs.push_back('{2'b00, 12, 2'b00, 2'b01, 2'b01, 2'b00});
        vecs.push_back('{2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b00});  // bounce
        vecs.push_back('{2'b00,  2, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b00,  2, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b01, 12, 2'b01, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b00, 12, 2'b00, 2'b01, 2'b01, 2'b00});
        vecs.push_back('{2'b10, 40, 2'b10, 2'b00, 2'b00, 2'b10});  // long press, key 1
        vecs.push_back('{2'b00, 12, 2'b00, 2'b10, 2'b00, 2'b00});
        vecs.push_back('{2'b01, 46, 2'b01, 2'b00, 2'b00, 2'b01});  // long (+repeats), key 0
        vecs.push_back('{2'b00, 12, 2'b00, 2'b01, 2'b00, 2'b00});
        vecs.push_back('{2'b11, 10, 2'b11, 2'b00, 2'b00, 2'b00});  // simultaneous
        vecs.push_back('{2'b00, 12, 2'b00, 2'b11, 2'b11, 2'b00});
        vecs.push_back('{2'b01,  8, 2'b01, 2'b00, 2'b00, 2'b00});  // independent overlap
        vecs.push_back('{2'b11,  8, 2'b10, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{2'b10,  8, 2'b00, 2'b01, 2'b01, 2'b00});
        vecs.push_back('{2'b00, 12, 2'b00, 2'b10, 2'b10, 2'b00});

        // Keys held through reset appear only after a full debounce.
        rst = 1'b1;
        key = 2'b11;
        repeat (5) tick();
        rst = 1'b0;
        push_ev(cyc + LAT, 2'b11, 2'b00, 2'b00, 2'b00);
        repeat (10) tick();
        key = 2'b00;
        push_ev(cyc + LAT, 2'b00, 2'b11, 2'b11, 2'b00);
        repeat (12) tick();

        foreach (vecs[i]) begin
            key = vecs[i].key;
            c   = cyc;
            if ((vecs[i].press | vecs[i].rel | vecs[i].shrt) != '0)
                push_ev(c + LAT, vecs[i].press, vecs[i].rel, vecs[i].shrt, 2'b00);
            if (vecs[i].lng != '0) begin
                push_ev(c + LAT + LONG, 2'b00, 2'b00, 2'b00, vecs[i].lng);
`ifdef KEY_REPEAT_EN
                for (int t = LAT + LONG + REP; t < vecs[i].dwell + LAT; t += REP)
                    push_ev(c + t, 2'b00, 2'b00, 2'b00, vecs[i].lng);
`endif
            end
            repeat (vecs[i].dwell) tick();
        end

        // Reset at hold cycle 10: silent drop to idle, then a fresh press.
        key = 2'b01;
        push_ev(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b00);
        repeat (LAT + 10 - 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_ev(cyc + LAT, 2'b01, 2'b00, 2'b00, 2'b00);
        repeat (14) tick();
        key = 2'b00;
        push_ev(cyc + LAT, 2'b00, 2'b01, 2'b01, 2'b00);
        repeat (12) tick();

        for (int n = 0; n < 200 && exp_q.size() > 0; n++) tick();
        if (exp_q.size() > 0) tmo = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_key_event_decoder
